ram_latency_model: RTL

- Word-addressed backing memory that sits directly downstream of the 2-way cache and serves its miss reads and write-through writes.
- Models a fixed multi-cycle access latency behind a `response` level handshake.
- A request is detected when any request input changes, matching how the cache drives its RAM port.
- Also provides saturating read/write access counters for miss-traffic measurement.

---
 rtl/ram_latency_model_if.sv | 23 ++
 rtl/ram_latency_model.sv | 104 ++++++++++
 2 files changed

// File: rtl/ram_latency_model_if.sv
// RAM-side port bundle between the 2-way cache and its backing memory model.
// The cache drives data/addr/wr; the RAM answers with response, read data and access counters.
interface ram_latency_model_if #(
  parameter int CNT_W = 16
) ();
  logic [31:0]      data;
  logic [31:0]      addr;
  logic             wr;
  logic             response;
  logic [31:0]      out;
  logic [CNT_W-1:0] rd_count;
  logic [CNT_W-1:0] wr_count;

  modport master (
    output data, addr, wr,
    input  response, out, rd_count, wr_count
  );

  modport slave (
    input  data, addr, wr,
    output response, out, rd_count, wr_count
  );
endinterface

// File: rtl/ram_latency_model.sv
// Word-addressed backing RAM with a fixed access latency and a level "response" handshake.
// Any change on data/addr/wr starts a new access and aborts one still in flight.
module ram_latency_model #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 4,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_latency_model_if.slave    bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_t           r_state;
  state_t           w_state_nx;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_nx;
  logic             r_first;
  logic [31:0]      r_data;
  logic [31:0]      r_addr;
  logic             r_wr;
  logic [31:0]      r_out;
  logic [CNT_W-1:0] r_rd_cnt;
  logic [CNT_W-1:0] r_wr_cnt;
  logic             w_new_req;
  logic             w_complete;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]      r_mem [DEPTH];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign w_idx = r_addr[ADDR_W-1:0];

  // Full 32-bit address compare: upper bits are ignored for indexing but still signal a new request.
  always_comb begin
    w_new_req  = r_first || (bus.data != r_data) || (bus.addr != r_addr) || (bus.wr != r_wr);
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_complete = 1'b0;
    if (w_new_req) begin
      w_state_nx = BUSY;
      w_cnt_nx   = LAT_M1;
    end else if (r_state == BUSY) begin
      if (r_cnt != 8'd0) begin
        w_cnt_nx = r_cnt - 8'd1;
      end else begin
        w_state_nx = IDLE;
        w_complete = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= 8'd0;
      r_first  <= 1'b1;
      r_data   <= 32'd0;
      r_addr   <= 32'd0;
      r_wr     <= 1'b0;
      r_out    <= 32'd0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nx;
      if (w_new_req) begin
        r_data  <= bus.data;
        r_addr  <= bus.addr;
        r_wr    <= bus.wr;
        r_first <= 1'b0;
      end
      if (w_complete && !r_wr) begin
        r_out    <= r_mem[w_idx];
        r_rd_cnt <= sat_inc(r_rd_cnt);
      end
      if (w_complete && r_wr) begin
        r_wr_cnt <= sat_inc(r_wr_cnt);
      end
    end
  end

  // Storage is never reset; a reset mid-access simply suppresses the commit.
  always_ff @(posedge clk) begin
    if (rst_n && w_complete && r_wr) begin
      r_mem[w_idx] <= r_data;
    end
  end

  assign bus.response = (r_state == IDLE);
  assign bus.out      = r_out;
  assign bus.rd_count = r_rd_cnt;
  assign bus.wr_count = r_wr_cnt;

endmodule
